// File: rtl/mux.sv
// Registered 4-to-1 multiplexer. Each bit is handled by its own lane, and the
// shared select register produces sel and a pulse whenever the select changes.

module mux_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       q
);
  // Indexing instead of a case statement lets an X/Z select reach q in simulation.
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d[s];
  end
endmodule

module mux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic             S0,
  input  logic             S1,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       sel,
  output logic             sel_changed
);
  logic [1:0]             s;
  logic [WIDTH-1:0][3:0]  lane_d;

  assign s = {S1, S0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign lane_d[i] = {I3[i], I2[i], I1[i], I0[i]};
    mux_lane u_lane (
      .clk (clk),
      .rst (rst),
      .d   (lane_d[i]),
      .s   (s),
      .q   (out[i])
    );
  end

  // sel_changed compares against the pre-edge sel, so it pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= 2'b00;
      sel_changed <= 1'b0;
    end else begin
      sel         <= s;
      sel_changed <= (s != sel);
    end
  end
endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux (WIDTH=4): directed scenarios followed by
// randomized traffic, all compared against a behavioural model.

module tb_mux;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] I0, I1, I2, I3;
  logic         S0, S1;
  logic [W-1:0] out;
  logic [1:0]   sel;
  logic         sel_changed;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_out;
  logic [1:0]   m_sel;
  logic         m_chg;

  mux #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .S0(S0), .S1(S1),
    .out(out), .sel(sel), .sel_changed(sel_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    checks++;
    assert (out === m_out) else begin
      failures++;
      $error("FAIL %s out: got %h want %h", tag, out, m_out);
    end
    checks++;
    assert (sel === m_sel) else begin
      failures++;
      $error("FAIL %s sel: got %b want %b", tag, sel, m_sel);
    end
    checks++;
    assert (sel_changed === m_chg) else begin
      failures++;
      $error("FAIL %s sel_changed: got %b want %b", tag, sel_changed, m_chg);
    end
  endtask

  // One rising edge: update the model from inputs seen at the edge, check, move to negedge.
  task automatic tick(input string tag);
    logic [W-1:0] vals [4];
    int s;
    @(posedge clk);
    vals[0] = I0; vals[1] = I1; vals[2] = I2; vals[3] = I3;
    s = {30'd0, S1, S0};
    if (rst) begin
      m_out = '0; m_sel = 2'b00; m_chg = 1'b0;
    end else begin
      m_chg = (s[1:0] != m_sel);
      m_sel = s[1:0];
      m_out = vals[s];
    end
    #1 chk(tag);
    @(negedge clk);
  endtask

  task automatic set_s(input int s);
    S1 = s[1]; S0 = s[0];
  endtask

  initial begin
    m_out = '0; m_sel = '0; m_chg = 1'b0;
    rst = 1'b1;
    I0 = 4'd1; I1 = 4'd1; I2 = 4'd1; I3 = 4'd1;
    set_s(3);
    @(negedge clk);

    // Reset held for two cycles, then release with S=11
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    tick("reset_release");

    // Full mapping sweep
    I0 = 4'd0; I1 = 4'd1; I2 = 4'd0; I3 = 4'd1;
    for (int s = 0; s < 4; s++) begin
      set_s(s);
      tick("sweep");
    end

    // Data tracking on S=10 with other inputs toggling at different rates
    set_s(2);
    for (int c = 0; c < 12; c++) begin
      I2 = {3'b000, c[0]};
      if (c % 2 == 0) I0 = ~I0;
      if (c % 3 == 0) I1 = ~I1;
      if (c % 5 == 0) I3 = ~I3;
      tick("track");
    end

    // Between-edge glitch on S0
    I0 = 4'd0; I1 = 4'd1; set_s(0);
    tick("glitch_setup");
    #1 S0 = 1'b1;
    #2 S0 = 1'b0;
    tick("glitch");
    tick("glitch_after");

    // Select-change pulse: hold 01, switch to 11
    I1 = 4'h5; I3 = 4'h9; set_s(1);
    for (int c = 0; c < 3; c++) tick("hold01");
    set_s(3);
    for (int c = 0; c < 3; c++) tick("hold11");

    // Mid-operation reset with I3=A
    I3 = 4'hA;
    tick("pre_rst");
    rst = 1'b1;
    tick("mid_rst");
    rst = 1'b0;
    tick("post_rst");

    // Randomized traffic with occasional reset
    for (int c = 0; c < 300; c++) begin
      I0 = W'($urandom); I1 = W'($urandom);
      I2 = W'($urandom); I3 = W'($urandom);
      if ($urandom_range(0, 3) == 0) set_s(int'($urandom_range(0, 3)));
      rst = ($urandom_range(0, 29) == 0);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
